// File: rtl/hb_pkg.sv
// hb_pkg: half-band coefficient set (Q15), tap count, FSM states and pair-coefficient lookup shared by interpolator and decimator
package hb_pkg;
  localparam int taps = 19;
  localparam int pairs = (taps + 1) / 4;
  localparam logic signed [15:0] h0_18 = 16'sh0025;
  localparam logic signed [15:0] h2_16 = 16'shFF17;
  localparam logic signed [15:0] h4_14 = 16'sh035B;
  localparam logic signed [15:0] h6_12 = 16'shF606;
  localparam logic signed [15:0] h8_10 = 16'sh2765;
  localparam logic signed [15:0] h9 = 16'sh4000;
  typedef enum logic [2:0] {IDLE, MAC, OUT_A, WAIT_B, OUT_B} state_t;
  function automatic logic signed [15:0] pair_coef(input logic [2:0] tap);
    return tap == 3'd0 ? h0_18 : tap == 3'd1 ? h2_16 : tap == 3'd2 ? h4_14 : tap == 3'd3 ? h6_12 : h8_10;
  endfunction
endpackage

// File: rtl/hb_interp_if.sv
// hb_interp_if: sample bus; ND/din into the interpolator, dout/dout_valid/dout_phase/overrun out of it
interface hb_interp_if #(parameter int DIN_W = 24, parameter int DOUT_W = DIN_W + 20);
  logic ND;
  logic signed [DIN_W-1:0] din;
  logic signed [DOUT_W-1:0] dout;
  logic dout_valid;
  logic dout_phase;
  logic overrun;
  modport master (output ND, din, input dout, dout_valid, dout_phase, overrun);
  modport slave (input ND, din, output dout, dout_valid, dout_phase, overrun);
endinterface

// File: rtl/hb_sym_mac.sv
// hb_sym_mac: registered symmetric-pair MAC; ports clk, rst, clr, en, tap, delay line x[10] in, acc out
module hb_sym_mac import hb_pkg::*; #(
  parameter int W = 24,
  parameter int ACC_W = W + 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [2:0]              tap,
  input  logic signed [W-1:0]     x [10],
  output logic signed [ACC_W-1:0] acc
);
  logic signed [W-1:0] xa, xb;
  logic signed [W:0] pair;
  logic signed [W+16:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  always_comb begin
    xa = x[{1'b0, tap}];
    xb = x[4'd9 - {1'b0, tap}];
    pair = (W+1)'(xa) + (W+1)'(xb);
    prod = (W+17)'(pair) * (W+17)'(pair_coef(tap));
    acc_d = clr ? '0 : en ? acc_q + ACC_W'(prod) : acc_q;
  end
  always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/hb_interp.sv
// hb_interp: 2x half-band interpolator, one shared MAC; ports clk, rst, bus (slave: ND/din in, dout/dout_valid/dout_phase/overrun out)
module hb_interp import hb_pkg::*; #(
  parameter int DIN_W = 24,
  parameter int DOUT_W = DIN_W + 20,
  parameter int HALF_PERIOD = 128
) (
  input logic        clk,
  input logic        rst,
  hb_interp_if.slave bus
);
  localparam int cw = $clog2(HALF_PERIOD) + 1;
  state_t state_q, state_d;
  logic [2:0] tap_q, tap_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic signed [DIN_W-1:0] x_q [10];
  logic signed [DIN_W-1:0] x_d [10];
  logic signed [DOUT_W-1:0] dout_q, dout_d, acc;
  logic dout_valid_q, dout_valid_d, dout_phase_q, dout_phase_d, overrun_q, overrun_d;
  logic mac_clr, mac_en;
  hb_sym_mac #(.W(DIN_W), .ACC_W(DOUT_W)) u_mac (
    .clk(clk), .rst(rst), .clr(mac_clr), .en(mac_en), .tap(tap_q), .x(x_q), .acc(acc)
  );
  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    cnt_d = cnt_q;
    x_d = x_q;
    dout_d = dout_q;
    dout_valid_d = 1'b0;
    dout_phase_d = dout_phase_q;
    overrun_d = overrun_q || (bus.ND && state_q != IDLE);
    mac_clr = 1'b0;
    mac_en = 1'b0;
    case (state_q)
      IDLE: if (bus.ND) begin
        x_d[0] = bus.din;
        for (int i = 1; i < 10; i++) x_d[i] = x_q[i-1];
        mac_clr = 1'b1;
        tap_d = 3'd0;
        state_d = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        tap_d = tap_q + 3'd1;
        state_d = tap_q == 3'(pairs - 1) ? OUT_A : MAC;
      end
      OUT_A: begin
        dout_d = acc;
        dout_phase_d = 1'b0;
        dout_valid_d = 1'b1;
        cnt_d = cw'(HALF_PERIOD - 1);
        state_d = WAIT_B;
      end
      WAIT_B: begin
        cnt_d = cnt_q - cw'(1);
        state_d = cnt_q == cw'(1) ? OUT_B : WAIT_B;
      end
      OUT_B: begin
        // centre tap is 0x4000, so h9*x is a plain shift
        dout_d = DOUT_W'(x_q[4]) <<< 14;
        dout_phase_d = 1'b1;
        dout_valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q <= '0;
      cnt_q <= '0;
      x_q <= '{default: '0};
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      dout_phase_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      dout_q <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_phase_q <= dout_phase_d;
      overrun_q <= overrun_d;
    end
  end
  assign bus.dout = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_phase = dout_phase_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_hb_interp.sv
// tb_hb_interp: randomized self-checking bench for hb_interp against a direct 19-tap FIR model
module tb_hb_interp;
  localparam int hp = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hb_interp_if #(.DIN_W(24), .DOUT_W(44)) bus ();
  hb_interp #(.DIN_W(24), .DOUT_W(44), .HALF_PERIOD(hp)) dut (.clk(clk), .rst(rst), .bus(bus));
  longint h [19] = '{37, 0, -233, 0, 859, 0, -2554, 0, 10085, 16384, 10085, 0, -2554, 0, 859, 0, -233, 0, 37};
  longint hist [$];
  int checks = 0;
  int passes = 0;
  function automatic longint m_even();
    longint s = 0;
    for (int j = 0; j < 10; j++) if (j < hist.size()) s += h[2*j] * hist[j];
    return s;
  endfunction
  function automatic longint m_odd();
    return hist.size() > 4 ? h[9] * hist[4] : 0;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ND = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
  endtask
  task automatic drive_sample(input logic signed [23:0] v, output longint ev, output longint od,
                              output int ca, output int cb, output logic pa, output logic pb, output int dbl);
    logic prev;
    prev = 1'b0;
    ca = -1; cb = -1; ev = 0; od = 0; pa = 1'b1; pb = 1'b0; dbl = 0;
    repeat ($urandom_range(0, 8)) @(negedge clk);
    @(negedge clk);
    bus.ND = 1'b1;
    bus.din = v;
    hist.push_front(longint'(v));
    @(negedge clk);
    bus.ND = 1'b0;
    bus.din = 24'($urandom);
    for (int c = 1; c <= hp + 40 && cb < 0; c++) begin
      @(negedge clk);
      if (bus.dout_valid && prev) dbl++;
      prev = bus.dout_valid;
      if (bus.dout_valid) begin
        if (ca < 0) begin ca = c; ev = bus.dout; pa = bus.dout_phase; end
        else begin cb = c; od = bus.dout; pb = bus.dout_phase; end
      end
    end
  endtask
  task automatic test_reset();
    int bad;
    rst = 1'b1;
    bus.ND = 1'b0;
    bus.din = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.dout !== 44'sd0) $display("FAIL reset_dout: got %0d want 0", bus.dout); else passes++;
    checks++; if (bus.dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.dout_valid); else passes++;
    checks++; if (bus.dout_phase !== 1'b0) $display("FAIL reset_phase: got %b want 0", bus.dout_phase); else passes++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun); else passes++;
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.dout_valid !== 1'b0 || bus.dout !== 44'sd0 || bus.overrun !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); else passes++;
  endtask
  task automatic test_stream(input string name, input int mode, input int count);
    logic signed [23:0] v;
    longint ev, od, ee, eo;
    int ca, cb, dbl;
    logic pa, pb;
    do_reset();
    for (int n = 0; n < count; n++) begin
      if (mode == 0) v = n == 0 ? 24'sd1 : 24'sd0;
      else if (mode == 1) v = 24'sd1000;
      else if (mode == 2) v = 24'sh800000;
      else v = 24'($urandom);
      drive_sample(v, ev, od, ca, cb, pa, pb, dbl);
      ee = m_even();
      eo = m_odd();
      checks++; if (ev !== ee) $display("FAIL %s_even[%0d]: got %0d want %0d", name, n, ev, ee); else passes++;
      checks++; if (od !== eo) $display("FAIL %s_odd[%0d]: got %0d want %0d", name, n, od, eo); else passes++;
      checks++; if (ca !== 6 || cb !== 6 + hp) $display("FAIL %s_latency[%0d]: got %0d/%0d want 6/%0d", name, n, ca, cb, 6 + hp); else passes++;
      checks++; if (pa !== 1'b0 || pb !== 1'b1) $display("FAIL %s_phase[%0d]: got %b/%b want 0/1", name, n, pa, pb); else passes++;
      checks++; if (dbl !== 0) $display("FAIL %s_double_strobe[%0d]: got %0d want 0", name, n, dbl); else passes++;
    end
    if (mode == 1) begin
      checks++; if (ev !== 64'sd16388000 || od !== 64'sd16384000) $display("FAIL dc_steady: got %0d/%0d want 16388000/16384000", ev, od); else passes++;
    end
    if (mode == 2) begin
      checks++; if (ev !== -64'sd137472507904 || od !== -64'sd137438953472) $display("FAIL negfs_steady: got %0d/%0d want -137472507904/-137438953472", ev, od); else passes++;
    end
  endtask
  task automatic test_overrun();
    logic signed [23:0] a;
    longint ev, od;
    int ca, cb, dbl;
    logic pa, pb;
    do_reset();
    a = 24'($urandom);
    ca = -1; cb = -1; ev = 0; od = 0;
    @(negedge clk);
    bus.ND = 1'b1;
    bus.din = a;
    hist.push_front(longint'(a));
    @(negedge clk);
    bus.ND = 1'b0;
    for (int c = 1; c <= hp + 40 && cb < 0; c++) begin
      @(negedge clk);
      if (c == 49) begin
        checks++; if (bus.overrun !== 1'b0) $display("FAIL overrun_early: got %b want 0", bus.overrun); else passes++;
      end
      // drops land on a WAIT_B edge and on the OUT_B edge
      bus.ND = c == 49 || c == hp + 5;
      bus.din = 24'sh5A5A5A;
      if (bus.dout_valid) begin
        if (ca < 0) begin ca = c; ev = bus.dout; end
        else begin cb = c; od = bus.dout; end
      end
    end
    bus.ND = 1'b0;
    checks++; if (ca !== 6 || cb !== 6 + hp) $display("FAIL overrun_latency: got %0d/%0d want 6/%0d", ca, cb, 6 + hp); else passes++;
    checks++; if (ev !== m_even() || od !== m_odd()) $display("FAIL overrun_outputs: got %0d/%0d want %0d/%0d", ev, od, m_even(), m_odd()); else passes++;
    checks++; if (bus.overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", bus.overrun); else passes++;
    drive_sample(24'($urandom), ev, od, ca, cb, pa, pb, dbl);
    checks++; if (ev !== m_even() || od !== m_odd()) $display("FAIL overrun_history: got %0d/%0d want %0d/%0d", ev, od, m_even(), m_odd()); else passes++;
    checks++; if (bus.overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", bus.overrun); else passes++;
  endtask
  task automatic test_reset_mid();
    longint ev, od;
    int ca, cb, dbl, strobes, bad;
    logic pa, pb;
    do_reset();
    strobes = 0;
    @(negedge clk);
    bus.ND = 1'b1;
    bus.din = 24'sd5;
    hist.push_front(5);
    @(negedge clk);
    bus.ND = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.dout_valid) strobes++;
    end
    checks++; if (strobes !== 1 || bus.dout !== m_even()) $display("FAIL mid_out_a: got %0d strobes dout %0d want 1 strobe dout %0d", strobes, bus.dout, m_even()); else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    checks++; if (bus.dout !== 44'sd0 || bus.dout_valid !== 1'b0 || bus.dout_phase !== 1'b0 || bus.overrun !== 1'b0)
      $display("FAIL mid_cleared: got dout %0d valid %b phase %b overrun %b want all 0", bus.dout, bus.dout_valid, bus.dout_phase, bus.overrun); else passes++;
    bad = 0;
    repeat (hp + 100) begin
      @(negedge clk);
      if (bus.dout_valid) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL mid_no_out_b: got %0d strobes want 0", bad); else passes++;
    drive_sample(24'sd1, ev, od, ca, cb, pa, pb, dbl);
    checks++; if (ev !== 64'sd37 || od !== 64'sd0) $display("FAIL mid_restart: got %0d/%0d want 37/0", ev, od); else passes++;
  endtask
  task automatic test_rst_nd();
    longint ev, od;
    int ca, cb, dbl, bad;
    logic pa, pb;
    @(negedge clk);
    rst = 1'b1;
    bus.ND = 1'b1;
    bus.din = 24'sd123;
    @(negedge clk);
    rst = 1'b0;
    bus.ND = 1'b0;
    hist.delete();
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.dout_valid) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL rst_nd_quiet: got %0d strobes want 0", bad); else passes++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL rst_nd_overrun: got %b want 0", bus.overrun); else passes++;
    drive_sample(24'sd1, ev, od, ca, cb, pa, pb, dbl);
    checks++; if (ev !== m_even() || od !== m_odd()) $display("FAIL rst_nd_first: got %0d/%0d want %0d/%0d", ev, od, m_even(), m_odd()); else passes++;
  endtask
  initial begin
    bus.ND = 1'b0;
    bus.din = '0;
    test_reset();
    test_stream("impulse", 0, 10);
    test_stream("dc", 1, 12);
    test_stream("negfs", 2, 12);
    test_stream("random", 3, 16);
    test_overrun();
    test_reset_mid();
    test_rst_nd();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
